// File: rtl/eeprom_slave_emu_pkg.sv
// Shared constants, field widths and FSM encoding for the EEPROM slave emulator.
package eeprom_slave_emu_pkg;

    localparam int OPCODE_WIDTH = 3;
    localparam int ADDR_WIDTH   = 9;
    localparam int DATA_WIDTH   = 8;
    localparam int FRAME_SIZE   = OPCODE_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam int CMD_BITS     = OPCODE_WIDTH + ADDR_WIDTH;
    localparam int SYNC_STAGES  = 2;
    localparam int CNT_WIDTH    = 5;

    localparam logic [OPCODE_WIDTH-1:0] OP_READ    = 3'b110;
    localparam logic [OPCODE_WIDTH-1:0] OP_WRITE   = 3'b101;
    localparam logic [DATA_WIDTH-1:0]   INIT_VALUE = 8'h00;

    // Bit counter landmarks: last command bit, full frame, saturation point.
    localparam logic [CNT_WIDTH-1:0] CNT_CMD_LAST = CNT_WIDTH'(CMD_BITS - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FRAME    = CNT_WIDTH'(FRAME_SIZE);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT      = CNT_WIDTH'(FRAME_SIZE + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD_DATA,
        ST_WR_DATA,
        ST_IGNORE
    } state_t;

    function automatic logic valid_opcode(input logic [OPCODE_WIDTH-1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/bus_sync_edge.sv
// Bus front-end synchroniser: brings one raw pin into the sys_clk domain and
// flags its rising and falling edges against a registered copy.
module bus_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Synchroniser chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_level = r_sync[STAGES-1];
    assign o_rise  = r_sync[STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/eeprom_mem.sv
// Single-port EEPROM image: synchronous read and write, cleared to INIT_VALUE
// by the asynchronous reset.
module eeprom_mem #(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_re,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Storage array and registered read port; reset restores the blank image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= INIT_VALUE;
            end
            r_rdata <= '0;
        end else begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end
            if (i_re) begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/eeprom_slave_emu.sv
// Serial EEPROM slave emulator: decodes 20-bit opcode/address/data frames,
// serves reads from an internal memory and commits complete writes at frame close.
module eeprom_slave_emu
    import eeprom_slave_emu_pkg::*;
(
    input  logic                    sys_clk,
    input  logic                    rst_n,
    input  logic                    ss_in,
    input  logic                    sclk_in,
    input  logic                    mosi_in,
    output logic                    miso_out,
    output logic                    frame_done,
    output logic                    frame_ok,
    output logic [OPCODE_WIDTH-1:0] frame_opcode,
    output logic [ADDR_WIDTH-1:0]   frame_addr,
    output logic [DATA_WIDTH-1:0]   frame_data,
    output logic                    busy
);

    logic w_ss_level, w_ss_rise, w_ss_fall;
    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_mosi, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    bus_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .i_async (ss_in),
        .o_level (w_ss_level),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    bus_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .i_async (sclk_in),
        .o_level (w_sclk_level),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    bus_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .i_async (mosi_in),
        .o_level (w_mosi),
        .o_rise  (w_mosi_rise),
        .o_fall  (w_mosi_fall)
    );

    assign w_unused = &{1'b0, w_sclk_level, w_mosi_rise, w_mosi_fall};

    state_t                  r_state;
    state_t                  w_state_next;
    logic [CNT_WIDTH-1:0]    r_count;
    logic [CMD_BITS-2:0]     r_shift;
    logic [OPCODE_WIDTH-1:0] r_opcode;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_tx;
    logic [DATA_WIDTH-1:0]   r_tx_data;
    logic                    r_load;
    logic                    r_miso;
    logic                    r_done;
    logic                    r_ok;
    logic [OPCODE_WIDTH-1:0] r_frame_opcode;
    logic [ADDR_WIDTH-1:0]   r_frame_addr;
    logic [DATA_WIDTH-1:0]   r_frame_data;

    logic [CMD_BITS-1:0]     w_cmd_word;
    logic                    w_decode;
    logic                    w_close;
    logic                    w_ok;
    logic                    w_mem_re;
    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_addr;
    logic [DATA_WIDTH-1:0]   w_mem_rdata;

    eeprom_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .INIT_VALUE (INIT_VALUE)
    ) u_mem (
        .clk     (sys_clk),
        .rst_n   (rst_n),
        .i_re    (w_mem_re),
        .i_we    (w_mem_we),
        .i_addr  (w_mem_addr),
        .i_wdata (r_shift[DATA_WIDTH-1:0]),
        .o_rdata (w_mem_rdata)
    );

    // FSM state register.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, command decode at the 12th rise, and frame-close qualification.
    always_comb begin
        w_state_next = r_state;
        w_cmd_word   = {r_shift, w_mosi};
        w_decode     = 1'b0;
        w_close      = 1'b0;
        w_ok         = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_addr   = r_addr;
        if (w_ss_rise) begin
            w_state_next = ST_CMD;
        end else if (w_ss_fall && (r_state != ST_IDLE)) begin
            w_close      = 1'b1;
            w_ok         = (r_count == CNT_FRAME) && valid_opcode(r_opcode);
            w_mem_we     = w_ok && (r_opcode == OP_WRITE);
            w_state_next = ST_IDLE;
        end else if ((r_state == ST_CMD) && w_sclk_rise && (r_count == CNT_CMD_LAST)) begin
            w_decode = 1'b1;
            case (w_cmd_word[CMD_BITS-1 -: OPCODE_WIDTH])
                OP_READ: begin
                    w_state_next = ST_RD_DATA;
                    w_mem_re     = 1'b1;
                    w_mem_addr   = w_cmd_word[ADDR_WIDTH-1:0];
                end
                OP_WRITE: w_state_next = ST_WR_DATA;
                default:  w_state_next = ST_IGNORE;
            endcase
        end
    end

    // Bit counting, shifting, MISO drive and latching of the frame report.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count        <= '0;
            r_shift        <= '0;
            r_opcode       <= '0;
            r_addr         <= '0;
            r_tx           <= '0;
            r_tx_data      <= '0;
            r_load         <= 1'b0;
            r_miso         <= 1'b0;
            r_done         <= 1'b0;
            r_ok           <= 1'b0;
            r_frame_opcode <= '0;
            r_frame_addr   <= '0;
            r_frame_data   <= '0;
        end else begin
            r_done <= 1'b0;
            r_load <= w_mem_re;
            if (r_load) begin
                r_tx      <= w_mem_rdata;
                r_tx_data <= w_mem_rdata;
            end
            if (w_ss_rise) begin
                r_count   <= '0;
                r_shift   <= '0;
                r_opcode  <= '0;
                r_addr    <= '0;
                r_tx      <= '0;
                r_tx_data <= '0;
                r_miso    <= 1'b0;
            end else if (w_close) begin
                r_done         <= 1'b1;
                r_ok           <= w_ok;
                r_frame_opcode <= r_opcode;
                r_frame_addr   <= r_addr;
                r_frame_data   <= (r_opcode == OP_READ) ? r_tx_data : r_shift[DATA_WIDTH-1:0];
                r_miso         <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (w_sclk_rise) begin
                    if (r_count != CNT_SAT) begin
                        r_count <= r_count + 1'b1;
                    end
                    r_shift <= {r_shift[CMD_BITS-3:0], w_mosi};
                    if (w_decode) begin
                        r_opcode <= w_cmd_word[CMD_BITS-1 -: OPCODE_WIDTH];
                        r_addr   <= w_cmd_word[ADDR_WIDTH-1:0];
                    end
                end
                if (w_sclk_fall) begin
                    if ((r_state == ST_RD_DATA) && (r_count < CNT_FRAME)) begin
                        r_miso <= r_tx[DATA_WIDTH-1];
                        r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
            end
        end
    end

    assign miso_out     = r_miso;
    assign frame_done   = r_done;
    assign frame_ok     = r_ok;
    assign frame_opcode = r_frame_opcode;
    assign frame_addr   = r_frame_addr;
    assign frame_data   = r_frame_data;
    assign busy         = w_ss_level;

endmodule
